keypad_digit_loader: RTL
========================

// Module: keypad_digit_loader
// PURPOSE
//  Consumer end of the keypad BCD encoder link: takes encoder BCD digit plus delayed-valid strobe, registers each keypress once.
//  Shifts accepted digits into an NUM_DIGITS-wide BCD time-entry register (MM:SS) for the microwave timer/display.
//  Rejects invalid codes, entries while loading is disabled, and entries beyond capacity; reports each outcome by pulse.
// PARAMETERS
//  NUM_DIGITS  4   digits in entry register (digit NUM_DIGITS-1 = most significant)
//  DIGIT_W     4   bits per BCD digit
//  BCD_MAX     9   largest accepted digit value
// PORTS
//  clk          in   1                  system clock (100 Hz), all logic on posedge
//  reset        in   1                  asynchronous, active-high reset
//  bcd_in       in   DIGIT_W            digit code from keypad encoder
//  strobe       in   1                  encoder delayed-valid; rising edge = new key, bcd_in stable while high
//  load_en      in   1                  1 = entry allowed (door closed, not cooking)
//  clear_entry  in   1                  synchronous clear of entry register, active-high
//  digits_out   out  NUM_DIGITS*DIGIT_W entry register, digit i at [i*DIGIT_W +: DIGIT_W]
//  digit_count  out  3                  digits accepted since last clear (0..NUM_DIGITS)
//  loaded       out  1                  digit_count != 0
//  key_accept   out  1                  1-cycle pulse: digit shifted in
//  key_reject   out  1                  1-cycle pulse: keypress discarded
// BEHAVIOUR
//  Reset: digits_out=0, digit_count=0, loaded=0, key_accept=0, key_reject=0, state=IDLE, strobe_q=1.
//   strobe_q resets to 1: a strobe already high at reset release is NOT a new key.
//  Edge detect: rise = strobe & ~strobe_q; strobe_q <= strobe every cycle.
//  FSM (3 states):
//   IDLE    : on rise -> latch bcd_in into key_q, go CAPTURE.
//   CAPTURE : one cycle; evaluate key_q; go HOLD if strobe=1, else IDLE.
//   HOLD    : wait for strobe=0 -> IDLE. No capture while in HOLD.
//  CAPTURE evaluation (priority order):
//   1. clear_entry=1        -> clear wins; no accept/reject pulse.
//   2. load_en=0            -> reject.
//   3. key_q > BCD_MAX      -> reject.
//   4. digit_count==NUM_DIGITS -> reject (register full; no wrap, no discard of MSD).
//   5. else accept: digits_out <= {digits_out[low NUM_DIGITS-1 digits], key_q}; digit_count+1.
//  Latency: rise sampled at edge n -> CAPTURE during cycle n+1 -> digits_out/digit_count and
//   key_accept or key_reject valid from edge n+2 for exactly one cycle (pulses registered, coincident with data).
//  clear_entry: any state, any cycle: digits_out=0, digit_count=0 next edge; FSM state unaffected.
//  loaded is combinational from digit_count (no extra latency).
//  Strobe glitch shorter than 1 cycle not sampled -> ignored; strobe held high = one key only.
//  Digit 0 as first key is accepted and counted (leading zero occupies a slot).
//  Reset mid-CAPTURE: no pulse emitted, register cleared, FSM -> IDLE.
// STRUCTURE
//  Shared package microwave_pkg: DIGIT_W, BCD_MAX, NUM_DIGITS defaults; state encodings
//   ST_IDLE=2'd0, ST_CAPTURE=2'd1, ST_HOLD=2'd2 (2'd3 unreachable -> IDLE).
//  Sub-module rise_detect (clk, reset, in, rise; reset value of delayed copy = 1) for strobe edge.
//  Remainder in one always block for FSM/registers plus output assigns.
// TESTING
//  1. Reset with strobe=1, release, hold 5 cycles -> no key_accept, digits_out=16'h0000.
//  2. load_en=1, keys 1,2,3,0 each strobe 6 cycles -> digits_out=16'h1230, digit_count=4, 4 accept pulses, each at rise+2.
//  3. Full register, key 5 -> key_reject 1 cycle, digits_out stays 16'h1230, digit_count=4.
//  4. bcd_in=4'hB strobe -> key_reject; load_en=0 with bcd_in=7 -> key_reject; register unchanged.
//  5. clear_entry high in same cycle as CAPTURE (key 8) -> digits_out=0, count=0, no pulse; next key 4 -> 16'h0004.
//  6. strobe held high 20 cycles with key 6 -> exactly one accept; reset asserted in CAPTURE cycle -> no pulse, all outputs 0.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared constants and FSM encodings for the microwave keypad/timer front end.
package microwave_pkg;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_BCD_MAX    = 9;
  localparam int COUNT_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } loader_state_t;

endpackage

// File: rtl/keypad_digit_loader_rise_detect.sv
// Rising-edge detector; the delayed copy resets high so a level already
// asserted when reset releases is not mistaken for a fresh edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_q <= 1'b1;
    else       in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/keypad_digit_loader.sv
// Registers one keypad digit per strobe edge into a shifting BCD MM:SS entry
// register, reporting each keypress as accepted or rejected.
module keypad_digit_loader
  import microwave_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int BCD_MAX    = DEF_BCD_MAX
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            bcd_in,
  input  logic                          strobe,
  input  logic                          load_en,
  input  logic                          clear_entry,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
  output logic [COUNT_W-1:0]            digit_count,
  output logic                          loaded,
  output logic                          key_accept,
  output logic                          key_reject
);

  loader_state_t                 state, state_next;
  logic [DIGIT_W-1:0]            key_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;
  logic [COUNT_W-1:0]            count_q;
  logic                          accept_q, reject_q;
  logic                          rise;
  logic                          do_accept, do_reject;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .in    (strobe),
    .rise  (rise)
  );

  // Capture outcome: a pending clear suppresses both pulses for this key.
  always_comb begin
    state_next = state;
    do_accept  = 1'b0;
    do_reject  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_next = strobe ? ST_HOLD : ST_IDLE;
        if (!clear_entry) begin
          if (!load_en || (key_q > DIGIT_W'(BCD_MAX)) ||
              (count_q == COUNT_W'(NUM_DIGITS)))
            do_reject = 1'b1;
          else
            do_accept = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!strobe) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      digits_q <= '0;
      count_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_next;
      accept_q <= do_accept;
      reject_q <= do_reject;
      if (state == ST_IDLE && rise) key_q <= bcd_in;
      // Full register refuses new digits rather than dropping the oldest.
      if (clear_entry) begin
        digits_q <= '0;
        count_q  <= '0;
      end else if (do_accept) begin
        digits_q <= {digits_q[(NUM_DIGITS-1)*DIGIT_W-1:0], key_q};
        count_q  <= count_q + COUNT_W'(1);
      end
    end
  end

  assign digits_out  = digits_q;
  assign digit_count = count_q;
  assign loaded      = (count_q != '0);
  assign key_accept  = accept_q;
  assign key_reject  = reject_q;

endmodule
